// File: rtl/mem_datos_ctrl.sv
// rtl/mem_datos_ctrl.sv - data-memory responder with fixed access latency and stall/done handshake
module mem_datos_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int LATENCIA = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              LeerMem,
   input  logic              EscrMem,
   input  logic [31:0]       Direccion,
   input  logic [DATA_W-1:0] DatoEscr,
   output logic [DATA_W-1:0] DatoLeido,
   output logic              Listo,
   output logic              Ocupado,
   output logic              ErrorMem
);

   typedef enum logic [1:0] {INACTIVO, ESPERA, RESPUESTA} estado_t;

   estado_t           estado_q, estado_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              op_escr_q, op_escr_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] dato_q, dato_d;
   logic [DATA_W-1:0] leido_q, leido_d;
   logic              listo_q, listo_d;
   logic              ocupado_q, ocupado_d;
   logic              error_q, error_d;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   logic pide, valida, fin_acceso, escr_ram;
   logic unused_dir;

   // Upper address bits are intentionally dropped so addresses wrap.
   assign unused_dir = ^Direccion[31:ADDR_W+2];

   always_comb begin
      pide       = LeerMem | EscrMem;
      valida     = (LeerMem ^ EscrMem) && (Direccion[1:0] == 2'b00);
      fin_acceso = (estado_q == ESPERA) && (cnt_q == 4'd1);
      escr_ram   = fin_acceso && op_escr_q;

      estado_d  = estado_q;
      cnt_d     = cnt_q;
      op_escr_d = op_escr_q;
      idx_d     = idx_q;
      dato_d    = dato_q;
      leido_d   = leido_q;
      listo_d   = 1'b0;
      ocupado_d = 1'b0;
      error_d   = 1'b0;

      case (estado_q)
         INACTIVO, RESPUESTA: begin
            if (valida) begin
               estado_d  = ESPERA;
               op_escr_d = EscrMem;
               idx_d     = Direccion[ADDR_W+1:2];
               dato_d    = DatoEscr;
               cnt_d     = 4'(LATENCIA);
               ocupado_d = 1'b1;
            end else begin
               estado_d = INACTIVO;
               error_d  = pide;
            end
         end
         ESPERA: begin
            if (fin_acceso) begin
               estado_d = RESPUESTA;
               cnt_d    = 4'd0;
               listo_d  = 1'b1;
               if (!op_escr_q) begin
                  leido_d = mem[idx_q];
               end
            end else begin
               cnt_d     = cnt_q - 4'd1;
               ocupado_d = 1'b1;
            end
         end
         default: estado_d = INACTIVO;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q  <= INACTIVO;
         cnt_q     <= 4'd0;
         op_escr_q <= 1'b0;
         idx_q     <= '0;
         dato_q    <= '0;
         leido_q   <= '0;
         listo_q   <= 1'b0;
         ocupado_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         op_escr_q <= op_escr_d;
         idx_q     <= idx_d;
         dato_q    <= dato_d;
         leido_q   <= leido_d;
         listo_q   <= listo_d;
         ocupado_q <= ocupado_d;
         error_q   <= error_d;
      end
   end

   // RAM is not reset; an async reset in ESPERA drops estado_q before the write edge.
   always_ff @(posedge clk) begin
      if (escr_ram) begin
         mem[idx_q] <= dato_q;
      end
   end

   assign DatoLeido = leido_q;
   assign Listo     = listo_q;
   assign Ocupado   = ocupado_q;
   assign ErrorMem  = error_q;

endmodule

// File: doc/mem_datos_ctrl.md
# mem_datos_ctrl

Data-memory responder for the single-cycle processor datapath. It consumes the `LeerMem`/`EscrMem` strobes that the control unit drives, services them against an internal word-addressed RAM with a fixed, parameterised access latency, and returns read data together with a completion handshake. While an access is outstanding it asserts a stall (`Ocupado`) so the processor can freeze its PC and register write-back.

## Interface
- `DATA_W`, 32, data word width in bits.
- `ADDR_W`, 8, word-address width; the RAM holds 2^ADDR_W words.
- `LATENCIA`, 2, wait cycles between request acceptance and completion; legal range 1..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `LeerMem`  in  1  read request strobe, level-sampled.
- `EscrMem`  in  1  write request strobe, level-sampled.
- `Direccion`  in  32  byte address; bits [ADDR_W+1:2] select the word.
- `DatoEscr`  in  DATA_W  write data.
- `DatoLeido`  out  DATA_W  read data; valid while `Listo`=1 after a read, held until the next read completes.
- `Listo`  out  1  one-cycle completion pulse.
- `Ocupado`  out  1  stall; high while an accepted access is waiting.
- `ErrorMem`  out  1  one-cycle pulse flagging a rejected request.

## Operation
- The FSM has three states: INACTIVO, ESPERA and RESPUESTA. All outputs are registered.
- **Acceptance.** A request is sampled only in INACTIVO or RESPUESTA.
  - Valid request: exactly one of `LeerMem`/`EscrMem` is high and `Direccion[1:0]`=0.
  - On a valid request, the block latches the operation, the word index and `DatoEscr`, loads the wait counter with LATENCIA, and moves to ESPERA.
- **Rejection.** `LeerMem`=`EscrMem`=1, or a misaligned address with either strobe high, is rejected.
  - No latch and no RAM access take place.
  - `ErrorMem`=1 for the next cycle.
  - The state goes to (or stays in) INACTIVO.
- **ESPERA.** The counter decrements each cycle.
  - The block ignores strobes and input changes; the latched values are used.
  - When the counter reaches 1:
    - write: RAM[idx] ← latched data;
    - read: `DatoLeido` ← RAM[idx].
  - Both are registered at that edge, and the state moves to RESPUESTA.
- **RESPUESTA.** Lasts exactly one cycle with `Listo`=1.
  - A valid request sampled in this cycle is accepted (back-to-back), with the next state ESPERA.
  - Otherwise the next state is INACTIVO.
- **Address range.** `Direccion` bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
- **Hazards.** A read issued back-to-back after a write to the same word returns the newly written data.
- **Reset.** Reset forces:
  - state INACTIVO, counter 0;
  - `Listo`=0, `Ocupado`=0, `ErrorMem`=0;
  - `DatoLeido`=0.
  
  RAM contents are not cleared. Reset during ESPERA discards the pending access: no write reaches the RAM.

## Timing
- Request sampled at edge k, in INACTIVO or RESPUESTA:
  - `Ocupado`=1 from edge k to edge k+LATENCIA (LATENCIA cycles).
  - RAM write or `DatoLeido` update happens at edge k+LATENCIA.
  - `Listo`=1 and `Ocupado`=0 during the cycle after edge k+LATENCIA.
- Rejected request at edge k: `ErrorMem`=1 from edge k to edge k+1. `Ocupado` stays 0.
- `Ocupado` and `Listo` are never high in the same cycle.
- Sustained throughput: one access per LATENCIA+1 cycles.
- `DatoLeido` is unchanged by writes, by rejected requests and while idle.

## Test plan
All scenarios use LATENCIA=2 and ADDR_W=8.
- **Reset values:** assert `reset` mid-cycle (asynchronous) → all outputs 0 immediately; after release the block is idle with `Ocupado`=0.
- **Write/read latency:** write 0xDEADBEEF to 0x10, then on its `Listo` cycle issue a read of 0x10 →
  - each access: `Ocupado` for 2 cycles, then `Listo` for 1 cycle;
  - the read shows `DatoLeido`=0xDEADBEEF during its `Listo` cycle.
- **Illegal requests:** `LeerMem`=`EscrMem`=1, or a read of 0x13 → `ErrorMem` pulse of 1 cycle, `Ocupado` stays 0, RAM word 0x10 unchanged.
- **Address wrap:** write 0x12345678 to 0x400, then read 0x000 → `DatoLeido`=0x12345678.
- **Input changes mid-access:** during ESPERA of a write to 0x20 (data 0xA5A5A5A5), toggle `Direccion`/`DatoEscr`/`LeerMem` → inputs ignored; a later read of 0x20 returns 0xA5A5A5A5.
- **Reset mid-write:** preload word 0x30 with 0x11111111, pulse `reset` in the first ESPERA cycle of a write of 0xFFFFFFFF to 0x30 → `Listo` never asserted; a subsequent read of 0x30 returns 0x11111111.
